glb_feeder: RTL and testbench
=============================

GLB_FEEDER -- requirements
Module: glb_feeder

Interface
REQ-001 SHALL have these ports, clock and reset first:
 clk  in  1  clock
 reset  in  1  reset, synchronous, active-high
 start  in  1  one-cycle pulse, begins one tile pass
 load_w  in  1  sampled at start; 1 = stream a weight phase before ifmap
 row_en  in  6  active PE rows, 1..32, sampled at start
 col_en  in  6  active PE columns, 1..32, sampled at start
 w_base, if_base, ip_base, op_base  in  16 each  GLB word base addresses, sampled at start
 busy  out  1  high from the cycle after start until done
 done  out  1  one-cycle pulse at end of pass
 glb_addr  out  16  GLB word address
 glb_ren  out  1  GLB read enable; glb_rdata is valid on the next cycle
 glb_wen  out  1  GLB write enable
 glb_wdata  out  32  GLB write data
 glb_rdata  in  32  GLB read data
 data_out  out  32  stream word to conv unit data_in
 valid_w, valid_if, valid_ip  out  1 each  stream valid, one per phase
 ready_w, ready_if, ready_ip  in  1 each  conv unit ready
 opsum_in  in  32  conv unit data_out
 valid_op  in  1  conv unit opsum valid
 ready_op  out  1  feeder accepts opsum

Function
REQ-002 Phase word counts SHALL be: weight = row_en*ceil(col_en/4); ifmap = col_en; ipsum = 2*row_en; opsum = 2*row_en.
REQ-003 The FSM SHALL have states IDLE, W_STREAM, IF_STREAM, IP_STREAM, OP_DRAIN, FINISH.
REQ-004 IDLE to W_STREAM SHALL occur on start with load_w=1; IDLE to IF_STREAM SHALL occur on start with load_w=0.
REQ-005 Phase transitions SHALL be W to IF to IP to OP_DRAIN to FINISH to IDLE, each advancing on the last handshake of its phase.
REQ-006 FINISH SHALL last exactly 1 cycle and assert done.
REQ-007 If row_en=0 or col_en=0 at start, the FSM SHALL go from IDLE to FINISH, with no GLB or stream traffic.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 Only the valid_* of the current phase SHALL be high; the others SHALL be 0.
REQ-010 A word SHALL transfer when valid_x && ready_x.
REQ-011 While valid_x && !ready_x, data_out and valid_x SHALL hold stable.
REQ-012 The k-th read of a phase SHALL use address base+k, 16-bit wrap-around.
REQ-013 No phase SHALL issue reads beyond its word count.
REQ-014 Reads SHALL be prefetched into a 2-entry skid so that, with ready held high, one word transfers per cycle.
REQ-015 First valid of a phase SHALL occur 2 cycles after phase entry.
REQ-016 Prefetch SHALL NOT cross a phase boundary; the next phase's first read SHALL issue in its entry cycle.
REQ-017 In OP_DRAIN: ready_op=1; glb_wen = valid_op && ready_op; glb_wdata = opsum_in; glb_addr = op_base+k.
REQ-018 In OP_DRAIN, idle cycles with valid_op=0 SHALL be tolerated indefinitely, with no timeout.
REQ-019 glb_ren and glb_wen SHALL never both be 1.
REQ-020 Outside OP_DRAIN, ready_op SHALL be 0.
REQ-021 Outside phase reads/writes, glb_addr SHALL be 0.

Reset
REQ-022 On reset, all outputs SHALL be 0, the FSM SHALL be IDLE, and the skid buffer and counters SHALL be cleared.
REQ-023 Reset mid-pass SHALL abort at the next edge with no done pulse; a later start SHALL run a full pass.

Structure
REQ-024 A shared package SHALL hold the state enum, GLB_AW=16, DW=32, ROW_MAX=32 and COL_MAX=32.
REQ-025 The sole sub-module SHALL be glb_rd_skid (2-entry read-latency skid FIFO).
REQ-026 glb_rd_skid SHALL expose: push from the delayed ren, pop on handshake, count, and flush on phase change or reset.

Verification
REQ-027 Bench SHALL check: load_w=1, row_en=4, col_en=8, ready always 1 -> 8 W words from w_base, 8 IF, 8 IP back-to-back; then 8 opsum writes to op_base..+7; done once.
REQ-028 Bench SHALL check: load_w=0, row_en=32, col_en=32 -> no valid_w; 32 IF words; 64 IP words; 64 writes.
REQ-029 Bench SHALL check: random ready_if stalls, 30% low -> data_out stable during stall; addresses if_base+0..7 each delivered once, in order.
REQ-030 Bench SHALL check: col_en=5, row_en=3 -> weight count 6 (3*2).
REQ-031 Bench SHALL check: w_base=16'hFFFE -> addresses FFFE, FFFF, 0000, ...
REQ-032 Bench SHALL check: row_en=0 -> done 1 cycle after the busy cycle, zero glb_ren.
REQ-033 Bench SHALL check: reset asserted in IP_STREAM -> next cycle all outputs 0, no done; restart completes normally.

Source files
------------

// File: rtl/glb_feeder_pkg.sv
// Shared definitions for the GLB feeder: widths, pass limits, FSM state
// encoding and the per-phase word-count helpers.
package glb_feeder_pkg;

  localparam int GLB_AW  = 16;
  localparam int DW      = 32;
  localparam int ROW_MAX = 32;
  localparam int COL_MAX = 32;

  // Row/column enables carry the value ROW_MAX/COL_MAX itself, hence the +1.
  localparam int ROW_W = $clog2(ROW_MAX) + 1;
  localparam int COL_W = $clog2(COL_MAX) + 1;
  localparam int CNT_W = GLB_AW;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_STREAM  = 3'd1,
    IF_STREAM = 3'd2,
    IP_STREAM = 3'd3,
    OP_DRAIN  = 3'd4,
    FINISH    = 3'd5
  } state_t;

  // Weights are packed four columns per GLB word.
  function automatic cnt_t w_words(input logic [ROW_W-1:0] rows,
                                   input logic [COL_W-1:0] cols);
    cnt_t r;
    cnt_t c;
    r = cnt_t'(rows);
    c = (cnt_t'(cols) + cnt_t'(3)) >> 2;
    return r * c;
  endfunction

  // Partial sums occupy two GLB words per active row.
  function automatic cnt_t ps_words(input logic [ROW_W-1:0] rows);
    return cnt_t'(rows) << 1;
  endfunction

endpackage

// File: rtl/glb_rd_skid.sv
// Two-entry FIFO that absorbs the one-cycle GLB read latency so a phase can
// stream one word per cycle while the consumer may stall at any time.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop all contents (phase change)
//   push        : glb_rdata is valid this cycle (read enable delayed by one)
//   push_data   : GLB read data
//   pop         : head consumed by a stream handshake
//   count       : number of stored words (0..2)
//   head        : oldest stored word
module glb_rd_skid
  import glb_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/glb_feeder.sv
// GLB feeder: for one tile pass, streams weight (optional), ifmap and ipsum
// words from the GLB to the conv unit, then drains opsum words back into GLB.
//   clk, reset            : clock, synchronous active-high reset
//   start, load_w         : pass start pulse, include weight phase
//   row_en, col_en        : active PE rows/columns (0 in either = empty pass)
//   w/if/ip/op_base       : GLB word base address of each phase
//   busy, done            : pass in progress, end-of-pass pulse
//   glb_addr/ren/wen/
//   glb_wdata/glb_rdata   : GLB port, read data one cycle after ren
//   data_out, valid_*,
//   ready_*               : stream to the conv unit, one valid per phase
//   opsum_in, valid_op,
//   ready_op              : opsum return from the conv unit
//
// state     | meaning
// IDLE      | waiting for start
// W_STREAM  | streaming row_en*ceil(col_en/4) weight words
// IF_STREAM | streaming col_en ifmap words
// IP_STREAM | streaming 2*row_en ipsum words
// OP_DRAIN  | writing 2*row_en opsum words to GLB
// FINISH    | one-cycle done pulse
module glb_feeder
  import glb_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_w,
  input  logic [ROW_W-1:0]  row_en,
  input  logic [COL_W-1:0]  col_en,
  input  logic [GLB_AW-1:0] w_base,
  input  logic [GLB_AW-1:0] if_base,
  input  logic [GLB_AW-1:0] ip_base,
  input  logic [GLB_AW-1:0] op_base,
  output logic              busy,
  output logic              done,
  output logic [GLB_AW-1:0] glb_addr,
  output logic              glb_ren,
  output logic              glb_wen,
  output logic [DW-1:0]     glb_wdata,
  input  logic [DW-1:0]     glb_rdata,
  output logic [DW-1:0]     data_out,
  output logic              valid_w,
  output logic              valid_if,
  output logic              valid_ip,
  input  logic              ready_w,
  input  logic              ready_if,
  input  logic              ready_ip,
  input  logic [DW-1:0]     opsum_in,
  input  logic              valid_op,
  output logic              ready_op
);

  state_t state;
  state_t state_nxt;

  logic [GLB_AW-1:0] w_base_q;
  logic [GLB_AW-1:0] if_base_q;
  logic [GLB_AW-1:0] ip_base_q;
  logic [GLB_AW-1:0] op_base_q;
  cnt_t              n_w_q;
  cnt_t              n_if_q;
  cnt_t              n_ip_q;
  cnt_t              n_op_q;

  cnt_t              rd_idx;
  cnt_t              xfer_idx;
  logic              ren_q;

  logic [1:0]        skid_count;
  logic [DW-1:0]     skid_head;

  logic              in_stream;
  logic [GLB_AW-1:0] ph_base;
  cnt_t              ph_len;
  logic              ph_ready;
  logic              stream_valid;
  logic              pop;
  logic              last_xfer;
  logic              write_hs;
  logic              last_write;
  logic              phase_chg;
  logic [2:0]        occupancy;
  logic              rd_room;

  // Per-phase view of the stream that is currently active.
  always_comb begin
    in_stream = 1'b0;
    ph_base   = '0;
    ph_len    = '0;
    ph_ready  = 1'b0;
    case (state)
      W_STREAM: begin
        in_stream = 1'b1;
        ph_base   = w_base_q;
        ph_len    = n_w_q;
        ph_ready  = ready_w;
      end
      IF_STREAM: begin
        in_stream = 1'b1;
        ph_base   = if_base_q;
        ph_len    = n_if_q;
        ph_ready  = ready_if;
      end
      IP_STREAM: begin
        in_stream = 1'b1;
        ph_base   = ip_base_q;
        ph_len    = n_ip_q;
        ph_ready  = ready_ip;
      end
      default: begin
        in_stream = 1'b0;
      end
    endcase
  end

  assign stream_valid = in_stream && (skid_count != 2'd0);
  assign pop          = stream_valid && ph_ready;
  assign last_xfer    = pop && (xfer_idx == ph_len - cnt_t'(1));
  assign write_hs     = (state == OP_DRAIN) && valid_op;
  assign last_write   = write_hs && (xfer_idx == n_op_q - cnt_t'(1));
  assign phase_chg    = (state_nxt != state);

  // Words buffered plus the read in flight, minus the one leaving now, must
  // leave room in the two-entry skid for the read being issued.
  assign occupancy = {1'b0, skid_count} + {2'b00, ren_q} - {2'b00, pop};
  assign rd_room   = (occupancy < 3'd2);

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    glb_addr  = '0;
    glb_ren   = 1'b0;
    glb_wen   = 1'b0;
    glb_wdata = '0;
    data_out  = '0;
    valid_w   = 1'b0;
    valid_if  = 1'b0;
    valid_ip  = 1'b0;
    ready_op  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if ((row_en == '0) || (col_en == '0)) begin
            state_nxt = FINISH;
          end else if (load_w) begin
            state_nxt = W_STREAM;
          end else begin
            state_nxt = IF_STREAM;
          end
        end
      end
      W_STREAM: begin
        if (last_xfer) state_nxt = IF_STREAM;
      end
      IF_STREAM: begin
        if (last_xfer) state_nxt = IP_STREAM;
      end
      IP_STREAM: begin
        if (last_xfer) state_nxt = OP_DRAIN;
      end
      OP_DRAIN: begin
        ready_op = 1'b1;
        glb_wen  = write_hs;
        if (write_hs) begin
          glb_wdata = opsum_in;
          glb_addr  = op_base_q + xfer_idx;
        end
        if (last_write) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (in_stream) begin
      glb_ren = rd_room && (rd_idx < ph_len);
      if (glb_ren) glb_addr = ph_base + rd_idx;
      if (stream_valid) data_out = skid_head;
      valid_w  = stream_valid && (state == W_STREAM);
      valid_if = stream_valid && (state == IF_STREAM);
      valid_ip = stream_valid && (state == IP_STREAM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_q  <= '0;
      if_base_q <= '0;
      ip_base_q <= '0;
      op_base_q <= '0;
      n_w_q     <= '0;
      n_if_q    <= '0;
      n_ip_q    <= '0;
      n_op_q    <= '0;
      rd_idx    <= '0;
      xfer_idx  <= '0;
      ren_q     <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        w_base_q  <= w_base;
        if_base_q <= if_base;
        ip_base_q <= ip_base;
        op_base_q <= op_base;
        n_w_q     <= load_w ? w_words(row_en, col_en) : '0;
        n_if_q    <= cnt_t'(col_en);
        n_ip_q    <= ps_words(row_en);
        n_op_q    <= ps_words(row_en);
      end
      // Every phase restarts its read and transfer indices from zero, and no
      // read is ever outstanding across a phase boundary.
      if (phase_chg) begin
        rd_idx   <= '0;
        xfer_idx <= '0;
        ren_q    <= 1'b0;
      end else begin
        ren_q <= glb_ren;
        if (glb_ren) rd_idx <= rd_idx + cnt_t'(1);
        if (pop || write_hs) xfer_idx <= xfer_idx + cnt_t'(1);
      end
    end
  end

  glb_rd_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (phase_chg),
    .push      (ren_q),
    .push_data (glb_rdata),
    .pop       (pop),
    .count     (skid_count),
    .head      (skid_head)
  );

endmodule

// File: tb/tb_glb_feeder.sv
// Self-checking bench for glb_feeder. A behavioural model holds, per pass, the
// ordered list of GLB reads, the expected words of each stream and the opsum
// write count; every cycle the DUT is compared against it.
module tb_glb_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load_w;
  logic [5:0]  row_en;
  logic [5:0]  col_en;
  logic [15:0] w_base, if_base, ip_base, op_base;
  logic        busy, done;
  logic [15:0] glb_addr;
  logic        glb_ren, glb_wen;
  logic [31:0] glb_wdata;
  logic [31:0] glb_rdata;
  logic [31:0] data_out;
  logic        valid_w, valid_if, valid_ip;
  logic        ready_w, ready_if, ready_ip;
  logic [31:0] opsum_in;
  logic        valid_op;
  logic        ready_op;

  glb_feeder dut (
    .clk(clk), .reset(reset), .start(start), .load_w(load_w),
    .row_en(row_en), .col_en(col_en),
    .w_base(w_base), .if_base(if_base), .ip_base(ip_base), .op_base(op_base),
    .busy(busy), .done(done),
    .glb_addr(glb_addr), .glb_ren(glb_ren), .glb_wen(glb_wen),
    .glb_wdata(glb_wdata), .glb_rdata(glb_rdata),
    .data_out(data_out), .valid_w(valid_w), .valid_if(valid_if), .valid_ip(valid_ip),
    .ready_w(ready_w), .ready_if(ready_if), .ready_ip(ready_ip),
    .opsum_in(opsum_in), .valid_op(valid_op), .ready_op(ready_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // GLB contents: each word carries its own address in the low half.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  always @(posedge clk) glb_rdata <= glb_ren ? mem_word(glb_addr) : $urandom();

  // Random consumer behaviour, percent of cycles held low.
  int stall_w = 0, stall_if = 0, stall_ip = 0, op_low = 0;
  always begin
    @(posedge clk);
    #1;
    ready_w  = (int'($urandom_range(99)) >= stall_w);
    ready_if = (int'($urandom_range(99)) >= stall_if);
    ready_ip = (int'($urandom_range(99)) >= stall_ip);
    valid_op = (int'($urandom_range(99)) >= op_low);
    opsum_in = $urandom();
  end

  // ---------------- behavioural model ----------------
  logic [15:0] q_str [3][$];   // expected stream word addresses: W, IF, IP
  logic [18:0] q_rd [$];       // {phase, address} of every read, in order
  int          op_left, op_k;
  logic [15:0] m_op_base;
  bit          active = 0;
  bit          rdy_hi = 0;
  bit          rst_seen = 0;
  int          start_cyc, mark_cyc, done_cyc;
  bit          seen_first [3];
  int          first_cyc [3];
  int          n_ph [3];
  int          hs_cnt [3];
  int          wr_cnt, done_cnt, ren_cnt;
  logic [15:0] w_log [$];
  logic [2:0]  prev_v, prev_r;
  logic [31:0] prev_data;

  // 0..2 stream phases, 3 opsum drain, 4 finish, 5 no pass
  function automatic int cur_ph();
    if (!active) return 5;
    for (int i = 0; i < 3; i++) if (q_str[i].size() != 0) return i;
    if (op_left > 0) return 3;
    return 4;
  endfunction

  always @(negedge clk) begin : cmp
    int ph, r, c, nw, nif, nip;
    bit pre_start, was_active, exp_busy, exp_done, exp_rop, exp_wen;
    logic [2:0] vv, rr, allowed;
    logic [15:0] a, ea;
    logic [18:0] e;
    vv = {valid_ip, valid_if, valid_w};
    rr = {ready_ip, ready_if, ready_w};
    if (reset) begin
      active = 0;
      rst_seen = 1;
      for (int i = 0; i < 3; i++) q_str[i].delete();
      q_rd.delete();
      op_left = 0;
    end else if (rst_seen) begin
      rst_seen = 0;
      check("reset_outputs_zero",
            {busy, done, |glb_addr, glb_ren, glb_wen, |glb_wdata, |data_out, vv, ready_op},
            '0);
    end else begin
      ph = cur_ph();
      was_active = active;
      pre_start = active && (cyc == start_cyc);
      allowed = (ph < 3 && !pre_start) ? (3'b001 << ph) : 3'b000;
      exp_busy = active && !pre_start;
      exp_done = exp_busy && (ph == 4);
      exp_rop  = exp_busy && (ph == 3);
      exp_wen  = exp_rop && valid_op;
      check("ctl", {busy, done, ready_op, glb_wen, vv & ~allowed, glb_ren & glb_wen,
                    (!glb_ren && !glb_wen && glb_addr != 16'h0)},
                   {exp_busy, exp_done, exp_rop, exp_wen, 3'b000, 1'b0, 1'b0});

      for (int i = 0; i < 3; i++)
        if (prev_v[i] && !prev_r[i])
          check("stall_hold", {vv[i], data_out}, {1'b1, prev_data});

      if (glb_ren) begin
        ren_cnt++;
        if (q_rd.size() == 0) check("read_in_budget", 1, 0);
        else begin
          e = q_rd.pop_front();
          check("read_addr", {3'(ph), glb_addr}, e);
        end
      end

      for (int i = 0; i < 3; i++) begin
        if (vv[i] && i == ph && !seen_first[i]) begin
          seen_first[i] = 1;
          first_cyc[i] = cyc;
          check("first_valid_latency", cyc - mark_cyc, 3);
        end
        if (vv[i] && rr[i]) begin
          hs_cnt[i]++;
          if (q_str[i].size() == 0) check("stream_in_budget", 1, 0);
          else begin
            a = q_str[i].pop_front();
            check("stream_data", data_out, mem_word(a));
            if (i == 0) w_log.push_back(data_out[15:0]);
            if (q_str[i].size() == 0) begin
              mark_cyc = cyc;
              if (rdy_hi) check("back_to_back", cyc - first_cyc[i], n_ph[i] - 1);
            end
          end
        end
      end

      if (glb_wen) begin
        wr_cnt++;
        if (op_left == 0) check("write_in_budget", 1, 0);
        else begin
          ea = m_op_base + 16'(op_k);
          check("op_write", {glb_addr, glb_wdata}, {ea, opsum_in});
          op_k++;
          op_left--;
        end
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (exp_done) begin
        check("pass_drained", q_rd.size(), 0);
        active = 0;
      end

      if (start && !was_active) begin
        r = int'(row_en);
        c = int'(col_en);
        if (r == 0 || c == 0) begin
          nw = 0; nif = 0; nip = 0;
        end else begin
          nw  = load_w ? r * ((c + 3) / 4) : 0;
          nif = c;
          nip = 2 * r;
        end
        for (int i = 0; i < 3; i++) begin
          q_str[i].delete();
          seen_first[i] = 0;
          hs_cnt[i] = 0;
        end
        q_rd.delete();
        w_log.delete();
        n_ph[0] = nw; n_ph[1] = nif; n_ph[2] = nip;
        for (int k = 0; k < nw; k++)  begin a = w_base + 16'(k);  q_str[0].push_back(a); q_rd.push_back({3'd0, a}); end
        for (int k = 0; k < nif; k++) begin a = if_base + 16'(k); q_str[1].push_back(a); q_rd.push_back({3'd1, a}); end
        for (int k = 0; k < nip; k++) begin a = ip_base + 16'(k); q_str[2].push_back(a); q_rd.push_back({3'd2, a}); end
        op_left = nip;
        op_k = 0;
        m_op_base = op_base;
        wr_cnt = 0; done_cnt = 0; ren_cnt = 0;
        start_cyc = cyc;
        mark_cyc = cyc;
        active = 1;
      end
    end
    prev_v = vv;
    prev_r = rr;
    prev_data = data_out;
  end

  // ---------------- stimulus ----------------
  task automatic setup_pass(input bit lw, input int r, input int c,
                            input logic [15:0] wb, input logic [15:0] ib,
                            input logic [15:0] pb, input logic [15:0] ob,
                            input int sw, input int si, input int sp, input int so);
    load_w = lw; row_en = 6'(r); col_en = 6'(c);
    w_base = wb; if_base = ib; ip_base = pb; op_base = ob;
    stall_w = sw; stall_if = si; stall_ip = sp; op_low = so;
    rdy_hi = (sw == 0 && si == 0 && sp == 0);
    repeat (2) @(posedge clk);
    #2 start = 1;
    @(posedge clk);
    #2 start = 0;
  endtask

  task automatic wait_pass(input bit poke);
    int n;
    n = 0;
    if (poke) begin
      repeat (4) @(posedge clk);
      if (active) begin
        #2 start = 1;
        @(posedge clk);
        #2 start = 0;
      end
    end
    while (active && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("pass_timeout", active, 0);
    if (active) begin
      #2 reset = 1;
      @(posedge clk);
      #2 reset = 0;
    end
    @(posedge clk);
  endtask

  initial begin
    int n;
    reset = 1; start = 0; load_w = 0; row_en = 0; col_en = 0;
    w_base = 0; if_base = 0; ip_base = 0; op_base = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    repeat (2) @(posedge clk);

    // Weight + ifmap + ipsum, all ready, opsum always valid.
    setup_pass(1, 4, 8, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0);
    wait_pass(0);
    check("t1_w_words", hs_cnt[0], 8);
    check("t1_if_words", hs_cnt[1], 8);
    check("t1_ip_words", hs_cnt[2], 8);
    check("t1_writes", wr_cnt, 8);
    check("t1_done_count", done_cnt, 1);

    // No weight phase, full array.
    setup_pass(0, 32, 32, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 0, 0);
    wait_pass(0);
    check("t2_w_words", hs_cnt[0], 0);
    check("t2_if_words", hs_cnt[1], 32);
    check("t2_ip_words", hs_cnt[2], 64);
    check("t2_writes", wr_cnt, 64);

    // Ifmap consumer stalls 30 % of cycles; start pulse while busy.
    setup_pass(0, 2, 8, 16'h0000, 16'h5550, 16'h6660, 16'h7770, 0, 30, 0, 40);
    wait_pass(1);
    check("t3_if_words", hs_cnt[1], 8);
    check("t3_done_count", done_cnt, 1);

    // Weight count rounds columns up to groups of four.
    setup_pass(1, 3, 5, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 10, 10, 10, 20);
    wait_pass(0);
    check("t4_w_words", hs_cnt[0], 6);

    // Weight addresses wrap at 16 bits.
    setup_pass(1, 2, 8, 16'hFFFE, 16'h0040, 16'h0080, 16'h00C0, 0, 0, 0, 0);
    wait_pass(0);
    check("t5_w_words", w_log.size(), 4);
    if (w_log.size() >= 3) begin
      check("t5_w_addr0", w_log[0], 16'hFFFE);
      check("t5_w_addr1", w_log[1], 16'hFFFF);
      check("t5_w_addr2", w_log[2], 16'h0000);
    end

    // Empty pass.
    setup_pass(1, 0, 8, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0);
    wait_pass(0);
    check("t6_done_delay", done_cyc - start_cyc, 1);
    check("t6_reads", ren_cnt, 0);
    check("t6_done_count", done_cnt, 1);

    // Reset during the ipsum phase, then a full pass.
    setup_pass(1, 4, 8, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0);
    n = 0;
    while (hs_cnt[2] < 2 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("t7_reached_ip", hs_cnt[2] >= 2, 1);
    #2 reset = 1;
    @(posedge clk);
    #2 reset = 0;
    repeat (20) @(posedge clk);
    check("t7_abort_no_done", done_cnt, 0);
    setup_pass(1, 4, 8, 16'h0900, 16'h0A00, 16'h0B00, 16'h0C00, 20, 20, 20, 30);
    wait_pass(0);
    check("t7_restart_ip_words", hs_cnt[2], 8);
    check("t7_restart_writes", wr_cnt, 8);
    check("t7_restart_done", done_cnt, 1);

    // Random passes.
    for (int t = 0; t < 12; t++) begin
      int r, c;
      r = int'($urandom_range(1, 32));
      c = int'($urandom_range(1, 32));
      if ($urandom_range(9) == 0) r = 0;
      setup_pass(1'($urandom_range(1)), r, c,
                 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
                 int'($urandom_range(50)), int'($urandom_range(50)),
                 int'($urandom_range(50)), int'($urandom_range(80)));
      wait_pass(1'($urandom_range(1)));
      check("rand_done_count", done_cnt, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
